// File: rtl/rail_sequencer_pkg.sv
// Shared encodings for the rail sequencer; the CPLD top also uses these for LED decode.
package rail_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_RAMP     = 3'b001,
    ST_SETTLE   = 3'b010,
    ST_RUN      = 3'b011,
    ST_SHUTDOWN = 3'b100,
    ST_FAULT    = 3'b101
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_TIMEOUT = 2'b01,
    CAUSE_PG_LOST = 2'b10
  } cause_e;

  localparam int MAX_RAILS = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Lowest set bit wins, so simultaneous pg losses report the lowest rail.
  function automatic logic [2:0] lowest_set(input logic [MAX_RAILS-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = MAX_RAILS - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rail_sequencer_pg_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous status bits.
module pg_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic r_meta;
      logic r_sync;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_meta <= 1'b0;
          r_sync <= 1'b0;
        end else begin
          r_meta <= i_async[gi];
          r_sync <= r_meta;
        end
      end

      assign o_sync[gi] = r_sync;
    end
  endgenerate

endmodule

// File: rtl/rail_sequencer.sv
// N-rail power sequencer: ordered power-up with pg timeout and settle,
// reverse-order timed shutdown, and latched fault reporting.
module rail_sequencer
  import rail_sequencer_pkg::*;
#(
  parameter int  NUM_RAILS     = 4,
  parameter int  TIMER_W       = 24,
  parameter int  PG_TIMEOUT    = 20000,
  parameter int  SETTLE_CYCLES = 400,
  parameter int  OFF_DELAY     = 400,
  localparam int FR_W          = clog2(NUM_RAILS)
) (
  input  logic                 sysclk,
  input  logic                 reset_INV,
  input  logic                 enable,
  input  logic                 clear_fault,
  input  logic [NUM_RAILS-1:0] pg,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 all_good,
  output logic                 fault,
  output logic [FR_W-1:0]      fault_rail,
  output logic [1:0]           fault_cause,
  output logic [2:0]           state
);

  localparam logic [TIMER_W-1:0] T_PG     = TIMER_W'(PG_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] T_SETTLE = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_OFF    = TIMER_W'(OFF_DELAY - 1);
  localparam logic [FR_W-1:0]    LAST_IDX = FR_W'(NUM_RAILS - 1);

  state_e               r_state;
  logic [NUM_RAILS-1:0] r_rail_en;
  logic [TIMER_W-1:0]   r_timer;
  logic [FR_W-1:0]      r_idx;
  logic                 r_all_good;
  logic                 r_fault;
  logic [FR_W-1:0]      r_fault_rail;
  cause_e               r_cause;

  logic [NUM_RAILS-1:0] w_pg_s;
  logic [NUM_RAILS-1:0] w_cur;
  logic                 w_cur_pg;
  logic [NUM_RAILS-1:0] w_en_low;
  logic [NUM_RAILS-1:0] w_below_low;
  logic [FR_W-1:0]      w_en_low_idx;
  logic [FR_W-1:0]      w_below_low_idx;
  logic                 w_trip;
  logic [FR_W-1:0]      w_trip_rail;
  cause_e               w_trip_cause;
  logic                 w_stop;

  pg_sync #(.WIDTH(NUM_RAILS)) u_pg_sync (
    .clk     (sysclk),
    .rst_n   (reset_INV),
    .i_async (pg),
    .o_sync  (w_pg_s)
  );

  assign w_cur           = NUM_RAILS'(1) << r_idx;
  assign w_cur_pg        = |(w_pg_s & w_cur);
  assign w_en_low        = r_rail_en & ~w_pg_s;
  assign w_below_low     = w_en_low & ~w_cur;
  assign w_en_low_idx    = FR_W'(lowest_set(MAX_RAILS'(w_en_low)));
  assign w_below_low_idx = FR_W'(lowest_set(MAX_RAILS'(w_below_low)));
  assign w_stop          = !enable &&
                           (r_state == ST_RAMP || r_state == ST_SETTLE || r_state == ST_RUN);

  always_comb begin
    w_trip       = 1'b0;
    w_trip_rail  = '0;
    w_trip_cause = CAUSE_NONE;
    case (r_state)
      ST_RAMP: begin
        if (|w_below_low) begin
          w_trip       = 1'b1;
          w_trip_rail  = w_below_low_idx;
          w_trip_cause = CAUSE_PG_LOST;
        end else if (!w_cur_pg && r_timer == T_PG) begin
          w_trip       = 1'b1;
          w_trip_rail  = r_idx;
          w_trip_cause = CAUSE_TIMEOUT;
        end
      end
      ST_SETTLE, ST_RUN: begin
        if (|w_en_low) begin
          w_trip       = 1'b1;
          w_trip_rail  = w_en_low_idx;
          w_trip_cause = CAUSE_PG_LOST;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      r_state      <= ST_IDLE;
      r_rail_en    <= '0;
      r_timer      <= '0;
      r_idx        <= '0;
      r_all_good   <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_rail <= '0;
      r_cause      <= CAUSE_NONE;
    end else if (w_trip || w_stop) begin
      // Enables are always a contiguous run from rail 0, so a right shift drops the highest rail.
      if (w_trip) begin
        r_fault      <= 1'b1;
        r_fault_rail <= w_trip_rail;
        r_cause      <= w_trip_cause;
      end
      r_state    <= ST_SHUTDOWN;
      r_rail_en  <= r_rail_en >> 1;
      r_timer    <= '0;
      r_all_good <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state   <= ST_RAMP;
            r_idx     <= '0;
            r_rail_en <= NUM_RAILS'(1);
            r_timer   <= '0;
          end
        end
        ST_RAMP: begin
          if (w_cur_pg) begin
            r_state <= ST_SETTLE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        ST_SETTLE: begin
          if (r_timer == T_SETTLE) begin
            r_timer <= '0;
            if (r_idx == LAST_IDX) begin
              r_state    <= ST_RUN;
              r_all_good <= 1'b1;
            end else begin
              r_idx     <= r_idx + FR_W'(1);
              r_rail_en <= r_rail_en | (w_cur << 1);
              r_state   <= ST_RAMP;
            end
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        ST_RUN: ;
        ST_SHUTDOWN: begin
          if (r_rail_en == '0) begin
            r_state <= r_fault ? ST_FAULT : ST_IDLE;
            r_timer <= '0;
          end else if (r_timer == T_OFF) begin
            r_rail_en <= r_rail_en >> 1;
            r_timer   <= '0;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        ST_FAULT: begin
          if (clear_fault && !enable) begin
            r_state      <= ST_IDLE;
            r_fault      <= 1'b0;
            r_fault_rail <= '0;
            r_cause      <= CAUSE_NONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rail_en     = r_rail_en;
  assign all_good    = r_all_good;
  assign fault       = r_fault;
  assign fault_rail  = r_fault_rail;
  assign fault_cause = r_cause;
  assign state       = r_state;

endmodule
